// File: rtl/apb_pkg.sv
// Shared APB definitions: completer state encoding, default bus widths, response codes.
package apb_pkg;

   localparam int APB_ADDR_W     = 8;
   localparam int APB_DATA_W     = 8;
   localparam int APB_WAIT_CNT_W = 4;

   localparam logic APB_RESP_OKAY   = 1'b0;
   localparam logic APB_RESP_SLVERR = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } apb_cmp_state_e;

endpackage

// File: rtl/apb_completer_mem_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
interface apb_completer_mem_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with zero flag; paces the wait states of one APB transfer.
module apb_wait_ctr
   import apb_pkg::*;
#(
   parameter int CNT_W = APB_WAIT_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/apb_completer_mem.sv
// APB completer backed by a DEPTH x DATA_W array, registered PREADY after WAIT_CYCLES waits.
// Optional macro APB_COMPLETER_RO_EN makes the top quarter of storage read-only.
//
// state | meaning
// IDLE  | no transfer in flight, waiting for a setup cycle
// WAIT  | setup captured, counting wait states of the access phase
// RESP  | PREADY high for one cycle; a clean write commits on its exit edge
module apb_completer_mem
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic         PCLK,
   input  logic         PRESET,
   apb_completer_mem_if.slave s_apb
);
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RO_BASE = (DEPTH * 3) / 4;
   localparam logic [APB_WAIT_CNT_W-1:0] CTR_INIT =
      (WAIT_CYCLES == 0) ? '0 : APB_WAIT_CNT_W'(WAIT_CYCLES - 1);

   apb_cmp_state_e r_state;
   apb_cmp_state_e w_state_nxt;

   logic [IDX_W-1:0]  r_idx;
   logic              r_write;
   logic [DATA_W-1:0] r_wdata;
   logic              r_err;
   logic              r_pready;
   logic              r_pslverr;
   logic [DATA_W-1:0] r_prdata;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_psel;
   logic              w_penable;
   logic              w_pwrite;
   logic [ADDR_W-1:0] w_paddr;
   logic [DATA_W-1:0] w_pwdata;
   logic              w_err_setup;
   logic              w_setup;
   logic              w_to_resp;
   logic              w_commit;
   logic              w_ctr_load;
   logic              w_ctr_dec;
   logic              w_ctr_zero;
   logic [IDX_W-1:0]  w_idx_cur;
   logic              w_write_cur;
   logic              w_err_cur;
   logic              w_resp_code;

   assign w_psel    = s_apb.PSEL;
   assign w_penable = s_apb.PENABLE;
   assign w_pwrite  = s_apb.PWRITE;
   assign w_paddr   = s_apb.PADDR;
   assign w_pwdata  = s_apb.PWDATA;

`ifdef APB_COMPLETER_RO_EN
   assign w_err_setup = (32'(w_paddr) >= 32'(DEPTH)) ||
                        (w_pwrite && (32'(w_paddr) >= 32'(RO_BASE)));
`else
   assign w_err_setup = (32'(w_paddr) >= 32'(DEPTH));
`endif

   // With zero wait states RESP is entered straight from the setup cycle, so use live inputs.
   assign w_idx_cur   = (r_state == IDLE) ? IDX_W'(w_paddr) : r_idx;
   assign w_write_cur = (r_state == IDLE) ? w_pwrite        : r_write;
   assign w_err_cur   = (r_state == IDLE) ? w_err_setup     : r_err;
   assign w_resp_code = w_err_cur ? APB_RESP_SLVERR : APB_RESP_OKAY;

   apb_wait_ctr #(
      .CNT_W (APB_WAIT_CNT_W)
   ) u_wait_ctr (
      .i_clk      (PCLK),
      .i_rst      (PRESET),
      .i_load     (w_ctr_load),
      .i_load_val (CTR_INIT),
      .i_dec      (w_ctr_dec),
      .o_zero     (w_ctr_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_setup     = 1'b0;
      w_to_resp   = 1'b0;
      w_commit    = 1'b0;
      w_ctr_load  = 1'b0;
      w_ctr_dec   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_psel && !w_penable) begin
               w_setup = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = RESP;
                  w_to_resp   = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_ctr_load  = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!w_psel) begin
               w_state_nxt = IDLE;
            end else if (w_penable) begin
               if (w_ctr_zero) begin
                  w_state_nxt = RESP;
                  w_to_resp   = 1'b1;
               end else begin
                  w_ctr_dec = 1'b1;
               end
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
            w_commit    = w_psel && w_penable && r_write && !r_err;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_err     <= 1'b0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_setup) begin
            r_idx   <= IDX_W'(w_paddr);
            r_write <= w_pwrite;
            r_wdata <= w_pwdata;
            r_err   <= w_err_setup;
         end
         r_pready  <= w_to_resp;
         r_pslverr <= w_to_resp ? w_resp_code : APB_RESP_OKAY;
         if (w_to_resp && !w_write_cur) begin
            r_prdata <= w_err_cur ? '0 : r_mem[w_idx_cur];
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign s_apb.PREADY  = r_pready;
   assign s_apb.PSLVERR = r_pslverr;
   assign s_apb.PRDATA  = r_prdata;
endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: two instances (2 and 0 wait states) checked through a scoreboard.
module tb_apb_completer_mem;
   import apb_pkg::*;

`ifdef APB_COMPLETER_RO_EN
   localparam logic RO_ON = 1'b1;
`else
   localparam logic RO_ON = 1'b0;
`endif

   typedef struct {
      logic       err;
      logic [7:0] rdata;
      logic       chk_rd;
      int         lat;
      string      tag;
   } exp_t;

   logic PCLK;
   logic PRESET;

   logic [1:0] d_psel;
   logic [1:0] d_pen;
   logic [1:0] d_pwr;
   logic [7:0] d_addr  [2];
   logic [7:0] d_wdata [2];
   logic [1:0] rdy;
   logic [1:0] err_o;
   logic [7:0] rdat    [2];

   exp_t exp_q [$];
   int   n_tests;
   int   n_fail;

   apb_completer_mem_if #(.ADDR_W(8), .DATA_W(8)) bus_w2 ();
   apb_completer_mem_if #(.ADDR_W(8), .DATA_W(8)) bus_w0 ();

   apb_completer_mem #(
      .ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)
   ) u_dut_w2 (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .s_apb  (bus_w2)
   );

   apb_completer_mem #(
      .ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)
   ) u_dut_w0 (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .s_apb  (bus_w0)
   );

   assign bus_w2.PSEL    = d_psel[0];
   assign bus_w2.PENABLE = d_pen[0];
   assign bus_w2.PWRITE  = d_pwr[0];
   assign bus_w2.PADDR   = d_addr[0];
   assign bus_w2.PWDATA  = d_wdata[0];
   assign bus_w0.PSEL    = d_psel[1];
   assign bus_w0.PENABLE = d_pen[1];
   assign bus_w0.PWRITE  = d_pwr[1];
   assign bus_w0.PADDR   = d_addr[1];
   assign bus_w0.PWDATA  = d_wdata[1];

   assign rdy[0]   = bus_w2.PREADY;
   assign rdy[1]   = bus_w0.PREADY;
   assign err_o[0] = bus_w2.PSLVERR;
   assign err_o[1] = bus_w0.PSLVERR;
   assign rdat[0]  = bus_w2.PRDATA;
   assign rdat[1]  = bus_w0.PRDATA;

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_all();
      for (int k = 0; k < 2; k++) begin
         d_psel[k] = 1'b0;
         d_pen[k]  = 1'b0;
      end
   endtask

   // b=0 -> 2 wait states, b=1 -> 0 wait states; chg flips PWDATA during the access phase.
   task automatic xfer(input int b, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic chg, input logic e_err, input logic [7:0] e_rd,
                       input string tag);
      exp_t e;
      int   n;
      e.err    = e_err;
      e.rdata  = e_rd;
      e.chk_rd = !wr;
      e.lat    = (b == 0) ? 3 : 1;
      e.tag    = tag;
      @(negedge PCLK);
      idle_all();
      d_psel[b]  = 1'b1;
      d_pen[b]   = 1'b0;
      d_pwr[b]   = wr;
      d_addr[b]  = a;
      d_wdata[b] = wd;
      exp_q.push_back(e);
      @(negedge PCLK);
      d_pen[b] = 1'b1;
      if (chg) d_wdata[b] = ~wd;
      for (n = 1; n <= 20; n++) begin
         #1;
         if (rdy[b]) break;
         @(negedge PCLK);
      end
      e = exp_q.pop_front();
      chk({e.tag, "_ready"}, 32'(rdy[b]), 32'd1);
      if (rdy[b]) begin
         chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
         chk({e.tag, "_slverr"}, 32'(err_o[b]), 32'(e.err));
         if (e.chk_rd) chk({e.tag, "_rdata"}, 32'(rdat[b]), 32'(e.rdata));
      end
   endtask

   initial begin
      logic seen;
      n_tests = 0;
      n_fail  = 0;
      PRESET  = 1'b1;
      d_psel  = '0;
      d_pen   = '0;
      d_pwr   = '0;
      for (int k = 0; k < 2; k++) begin
         d_addr[k]  = '0;
         d_wdata[k] = '0;
      end
      repeat (3) @(posedge PCLK);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready",  32'(rdy[k]),   32'd0);
         chk("rst_slverr", 32'(err_o[k]), 32'd0);
         chk("rst_rdata",  32'(rdat[k]),  32'd0);
      end
      @(negedge PCLK);
      PRESET = 1'b0;

      xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, "w0_rd00");

      xfer(0, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 8'h00, "wr05");
      xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'hA5, "rd05");

      xfer(0, 1'b1, 8'h40, 8'h3C, 1'b0, 1'b1, 8'h00, "wr40_oor");
      xfer(0, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h00, "rd40_oor");
      xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, "rd00_alias");
      xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'hA5, "rd05_keep");

      xfer(0, 1'b1, 8'h06, 8'h5A, 1'b1, 1'b0, 8'h00, "wr06_chg");
      xfer(0, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 8'h5A, "rd06");

      // abort: drop PSEL after one access cycle of a write
      @(negedge PCLK);
      idle_all();
      d_psel[0] = 1'b1; d_pen[0] = 1'b0; d_pwr[0] = 1'b1;
      d_addr[0] = 8'h10; d_wdata[0] = 8'h77;
      @(negedge PCLK);
      d_pen[0] = 1'b1;
      @(negedge PCLK);
      seen = 1'b0;
      idle_all();
      for (int k = 0; k < 5; k++) begin
         #1;
         if (rdy[0]) seen = 1'b1;
         @(negedge PCLK);
      end
      chk("abort_ready", 32'(seen), 32'd0);
      xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, "rd10_abort");

      xfer(1, 1'b1, 8'h07, 8'h3E, 1'b0, 1'b0, 8'h00, "w0_wr07");
      xfer(1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 8'h3E, "w0_rd07");
      xfer(1, 1'b1, 8'h41, 8'h12, 1'b0, 1'b1, 8'h00, "w0_wr41_oor");

      xfer(0, 1'b1, 8'h30, 8'h11, 1'b0, RO_ON, 8'h00, "wr30");
      xfer(0, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, RO_ON ? 8'h00 : 8'h11, "rd30");
      xfer(0, 1'b1, 8'h2F, 8'h22, 1'b0, 1'b0, 8'h00, "wr2f");
      xfer(0, 1'b0, 8'h2F, 8'h00, 1'b0, 1'b0, 8'h22, "rd2f");

      // reset during the wait phase of a write to 0x08
      @(negedge PCLK);
      idle_all();
      d_psel[0] = 1'b1; d_pen[0] = 1'b0; d_pwr[0] = 1'b1;
      d_addr[0] = 8'h08; d_wdata[0] = 8'h99;
      @(negedge PCLK);
      d_pen[0] = 1'b1;
      #2;
      PRESET = 1'b1;
      #1;
      chk("midrst_ready",    32'(rdy[0]),   32'd0);
      chk("midrst_slverr",   32'(err_o[0]), 32'd0);
      chk("midrst_rdata",    32'(rdat[0]),  32'd0);
      chk("midrst_w0_rdata", 32'(rdat[1]),  32'd0);
      idle_all();
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      xfer(0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, "rd08_rst");
      xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, "rd05_rst");

      @(negedge PCLK);
      idle_all();
      repeat (2) @(negedge PCLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/apb_completer_mem.md
Name: apb_completer_mem

Overview:
- APB completer (slave) that answers transfers from the master bridge.
- Backed by a DEPTH x DATA_W storage array.
- Generates registered PREADY with a fixed number of wait states, PRDATA for reads, and PSLVERR for out-of-range addresses.
- One instance sits behind each PSELx decode of the bridge; it replaces the combinational slaves.

Parameters:
- ADDR_W, 8, width of PADDR as seen by the completer.
- DATA_W, 8, width of PWDATA/PRDATA.
- DEPTH, 64, number of storage words; valid addresses 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states inserted per transfer (range 0..15).

Ports:
- PCLK  in  1  clock, all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  completer select from bridge.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  transfer address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid when PREADY=1 on a read.
- PREADY  out  1  transfer completion, registered.
- PSLVERR  out  1  error response, valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, async): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, all storage words=0.
- States:
  - IDLE: PREADY=0.
  - WAIT: counting wait states, PREADY=0.
  - RESP: PREADY=1 for exactly one cycle.
- IDLE:
  - Setup cycle is PSEL=1, PENABLE=0. On it, capture PADDR, PWRITE, PWDATA.
  - err = (captured addr >= DEPTH).
  - If WAIT_CYCLES==0, go to RESP; else go to WAIT with cnt=WAIT_CYCLES-1.
  - PSEL=1 with PENABLE=1 and no preceding setup: ignored, stay IDLE.
- WAIT:
  - Each edge with PSEL=1 and PENABLE=1: if cnt==0 go to RESP, else decrement cnt.
  - PSEL=0 (abort): go to IDLE, no storage update, PREADY stays 0.
- Entry to RESP:
  - PREADY<=1, PSLVERR<=err.
  - Read, no error: PRDATA<=mem[addr].
  - Read with error: PRDATA<=0.
  - Write: PRDATA holds its previous value.
- RESP:
  - On the edge with PSEL=1 and PENABLE=1, a write with err=0 commits mem[addr]<=captured PWDATA.
  - Always go to IDLE; PREADY<=0, PSLVERR<=0.
- Latency: PREADY is high in the (WAIT_CYCLES+1)th access cycle. A full transfer is WAIT_CYCLES+2 cycles.
- Back-to-back: a new setup in the cycle after RESP is accepted from IDLE with no bubble.
- Writes use the PWDATA captured in the setup cycle; later PWDATA changes are ignored.
- An erroring write never modifies storage. A read of a just-written address in the next transfer returns the new value.
- Reset mid-transfer: immediate return to IDLE, outputs to reset values, and any pending write is discarded.
- PSLVERR is never 1 while PREADY=0.

Optional Feature:
- Macro APB_COMPLETER_RO_EN.
- When defined: addresses in the top quarter of storage (DEPTH*3/4..DEPTH-1) are read-only. A write there completes with PSLVERR=1 and no storage update; reads there behave normally.
- When undefined: every in-range address is read/write, and only addr>=DEPTH raises PSLVERR.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum apb_cmp_state_e {IDLE, WAIT, RESP};
  - the default widths APB_ADDR_W=8 and APB_DATA_W=8;
  - the error-code constants.
- The master bridge and completer both import apb_pkg.
- Sub-module apb_wait_ctr: a loadable down-counter with a zero flag, instanced once to produce the WAIT to RESP condition.
- The storage array stays inline.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Setup write addr=0x05 data=0xA5 -> PREADY rises in the 3rd access cycle, PSLVERR=0.
  - Read addr=0x05 -> PRDATA=0xA5 with PREADY=1.
- WAIT_CYCLES=0: read addr=0x00 after reset -> PREADY=1 in the first access cycle, PRDATA=0x00, total 2 cycles.
- Out-of-range, DEPTH=64:
  - Write addr=0x40 data=0x3C -> PREADY=1 with PSLVERR=1.
  - Read addr=0x40 -> PSLVERR=1, PRDATA=0x00.
  - Read of any in-range address still shows pre-write contents.
- Abort: setup write addr=0x10 data=0x77, then drop PSEL during WAIT -> no PREADY; a subsequent read of 0x10 returns 0x00.
- Reset mid-transfer: assert PRESET during WAIT of a write to 0x08 -> PREADY/PSLVERR/PRDATA=0 immediately; after release, a read of 0x08 returns 0x00.
- APB_COMPLETER_RO_EN defined:
  - Write addr=0x30 data=0x11 -> PSLVERR=1, read of 0x30 returns 0x00.
  - Write addr=0x2F data=0x22 -> PSLVERR=0, read returns 0x22.
